// File: rtl/gcn_read_arbiter.sv
// Round-robin arbiter sharing one memory read port between weight fetch (0) and
// feature fetch (1), with per-requester address window checks and rvalid return.
module gcn_read_arbiter #(
  parameter int unsigned              ADDRESS_WIDTH       = 13,
  parameter int unsigned              READ_LATENCY        = 2,
  parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_ADDRESS_MIN  = ADDRESS_WIDTH'(12'h000),
  parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_ADDRESS_MAX  = ADDRESS_WIDTH'(12'h0FF),
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_ADDRESS_MIN = ADDRESS_WIDTH'(12'h200),
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_ADDRESS_MAX = ADDRESS_WIDTH'(12'h2FF)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          halt,
  input  logic [0:1]                    req,
  input  logic [0:1][ADDRESS_WIDTH-1:0] req_addr,
  output logic [0:1]                    gnt,
  output logic [ADDRESS_WIDTH-1:0]      read_address,
  output logic                          enable_read,
  output logic [0:1]                    rvalid,
  output logic [0:1]                    addr_err,
  output logic                          idle
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic                    last_grant;
  logic                    issue_owner;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_own;
  logic [0:1]              legal;
  logic                    pipe_empty;
  logic                    grant_en;
  logic                    sel;
  logic                    legal_grant;

  // Offset-from-minimum compare: one unsigned test covers both window bounds.
  assign legal[0] = (req_addr[0] - WEIGHT_ADDRESS_MIN)  <= (WEIGHT_ADDRESS_MAX  - WEIGHT_ADDRESS_MIN);
  assign legal[1] = (req_addr[1] - FEATURE_ADDRESS_MIN) <= (FEATURE_ADDRESS_MAX - FEATURE_ADDRESS_MIN);

  assign pipe_empty  = !enable_read && !(|tag_vld);
  assign idle        = (state == IDLE) && pipe_empty;
  assign sel         = (req[0] && req[1]) ? ~last_grant : req[1];
  assign grant_en    = reset && !halt && (|req) && (state != DRAIN);
  assign legal_grant = grant_en && legal[sel];

  assign rvalid[0] = tag_vld[READ_LATENCY-1] && !tag_own[READ_LATENCY-1];
  assign rvalid[1] = tag_vld[READ_LATENCY-1] &&  tag_own[READ_LATENCY-1];

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    if (grant_en) gnt[sel] = 1'b1;
    case (state)
      IDLE:    if (!halt && (|req)) state_nxt = RUN;
      RUN: begin
        if (halt)                        state_nxt = DRAIN;
        else if (!(|req) && pipe_empty)  state_nxt = IDLE;
      end
      DRAIN:   if (pipe_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      issue_owner  <= 1'b0;
      read_address <= '0;
      enable_read  <= 1'b0;
      addr_err     <= '0;
      tag_vld      <= '0;
      tag_own      <= '0;
    end else begin
      state       <= state_nxt;
      enable_read <= legal_grant;
      addr_err    <= addr_err | (gnt & ~legal);
      if (legal_grant) begin
        read_address <= req_addr[sel];
        issue_owner  <= sel;
        last_grant   <= sel;
      end
      // Tags enter on the enable_read cycle so the last stage lines up with data.
      tag_vld[0] <= enable_read;
      tag_own[0] <= issue_owner;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_own[k] <= tag_own[k-1];
      end
    end
  end

endmodule

// File: doc/gcn_read_arbiter.md
Name: gcn_read_arbiter

Overview:
- Shares the single feature/weight memory read port (read_address, enable_read) between two requesters: requester 0 (weight fetch) and requester 1 (feature fetch).
- Arbitrates round-robin, one read per cycle, and range-checks each address against its requester's window.
- Tracks in-flight reads and returns a per-requester valid pulse when memory data is present.
- Sits between the transformation-stage fetch logic and the memory model/top-level read port.

Parameters:
- ADDRESS_WIDTH, 13, read address width
- READ_LATENCY, 2, cycles from enable_read high to data valid on the memory data bus (range 1..7)
- WEIGHT_ADDRESS_MIN, 12'h0, lowest legal requester-0 address
- WEIGHT_ADDRESS_MAX, 12'hFF, highest legal requester-0 address
- FEATURE_ADDRESS_MIN, 12'h200, lowest legal requester-1 address
- FEATURE_ADDRESS_MAX, 12'h2FF, highest legal requester-1 address

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- halt  input  1  stop granting; drain in-flight reads
- req  input  [0:1] x 1  read request per requester, level, held until granted
- req_addr  input  [0:1] x ADDRESS_WIDTH  address per requester, stable while req high
- gnt  output  [0:1] x 1  combinational one-hot grant, same cycle as accepted req
- read_address  output  ADDRESS_WIDTH  registered memory address
- enable_read  output  1  registered memory read strobe
- rvalid  output  [0:1] x 1  data-valid pulse routed to the owning requester
- addr_err  output  [0:1] x 1  sticky out-of-range flag per requester
- idle  output  1  high when no read is in flight and the FSM is IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; gnt=0; read_address=0; enable_read=0; rvalid=0; addr_err=0; idle=1; last_grant=1, so requester 0 wins the first tie; tag pipeline cleared.
- Range check: req_addr[0] is legal if it lies in [WEIGHT_ADDRESS_MIN, WEIGHT_ADDRESS_MAX] inclusive. req_addr[1] is legal if it lies in [FEATURE_ADDRESS_MIN, FEATURE_ADDRESS_MAX]. Comparisons are unsigned and zero-extended to ADDRESS_WIDTH.
- Illegal request:
  - never granted and never issued;
  - sets addr_err[i] the next cycle; the flag is sticky until reset;
  - gnt[i] pulses anyway, so the requester does not hang.
  - The pulse consumes an arbitration slot and does not change last_grant.
- FSM states:
  - IDLE: no request pending. Go to RUN when any req is high and halt=0.
  - RUN: grants one requester per cycle.
    - Both requesting: grant the one not equal to last_grant; last_grant updates on each legal grant.
    - One requesting: grant it.
    - Go to DRAIN on halt=1. Go to IDLE when no req and the pipeline is empty.
  - DRAIN: gnt held 0; wait until the tag pipeline is empty, then go to IDLE. halt is ignored after entry.
- In IDLE with req high and halt=0, the grant is given the same cycle; the state transition is not a bubble.
- Issue timing: a legal grant in cycle t gives read_address=req_addr[i] and enable_read=1 in cycle t+1. With no grant, enable_read=0 and read_address holds its value.
- Return path:
  - A READ_LATENCY-deep shift register carries {valid, owner} per issued read.
  - rvalid[owner]=1 exactly READ_LATENCY cycles after the corresponding enable_read cycle, for one cycle.
  - Back-to-back issues give back-to-back rvalid in issue order.
- Throughput: one read per cycle sustained. Alternating grants under continuous dual request.
- idle = (state==IDLE) and tag pipeline empty.
- halt in the same cycle as req: halt wins, no grant that cycle. Reads issued earlier still complete with rvalid.
- Reset mid-operation: everything clears immediately. Pending rvalid pulses are discarded and are never produced after reset release.
- Grant without req is forbidden. gnt is always one-hot or zero.

Test Plan:
- Reset with req=11 held → gnt=00, enable_read=0, idle=1. First cycle after release: gnt=10 (requester 0), then enable_read=1 with read_address=req_addr[0].
- Continuous req=11, addr0=0x010, addr1=0x210, READ_LATENCY=2 → gnt alternates 10,01,10,…; read_address alternates 0x010/0x210. rvalid alternates, starting 2 cycles after the first enable_read.
- Single requester req[1] for 4 cycles, addrs 0x200–0x203 → 4 consecutive enable_read cycles, then 4 rvalid[1] pulses.
- req[0] with addr 0x150 (illegal) → gnt[0] pulses, no enable_read, addr_err[0]=1 next cycle and stays 1. A following legal req[0]=0x0FF issues normally.
- Two reads issued, then halt=1 with req=11 → gnt=00 from the halt cycle, both rvalid still arrive, idle=1 afterwards. halt=0 with req → grants resume.
- Assert reset one cycle after an issue → rvalid never pulses for that read. All outputs are at their reset values during reset and on the first cycle after release.
